// File: rtl/lt24_reset_sequencer.sv
// LT24 LCD reset sequencer: turns the PIO reset bit into a reset pulse with a
// minimum low time and a post-release settle delay, plus an Avalon-MM status slave.
module lt24_reset_sequencer #(
  parameter int unsigned LOW_CYCLES     = 500,
  parameter int unsigned RELEASE_CYCLES = 6000000,
  parameter int unsigned CNT_W          = 23
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ctrl_reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_reset_n,
  output logic        lcd_ready
);

  localparam int unsigned CNT_RST_W = 16;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       timer_q, timer_d;
  logic [CNT_RST_W-1:0]   reset_count_q, reset_count_d;
  logic                   lcd_reset_n_q, lcd_reset_n_d;
  logic                   lcd_ready_q, lcd_ready_d;
  logic                   cnt_inc;
  logic                   cnt_clr;

  // Write data carries no information; only the address of a write matters.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Next-state and timer logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_ASSERT: begin
        if (timer_q == LOW_LAST) begin
          if (ctrl_reset_n) begin
            state_d = ST_WAIT;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!ctrl_reset_n) begin
          state_d = ST_ASSERT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
          if (timer_q == REL_LAST) begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (!ctrl_reset_n) begin
          state_d = ST_ASSERT;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        timer_d = '0;
      end
    endcase
  end

  // Outputs follow the next state so they change on the same edge as the FSM.
  always_comb begin
    lcd_reset_n_d = (state_d != ST_ASSERT);
    lcd_ready_d   = (state_d == ST_READY);
  end

  // Re-entry counter; a software clear beats a simultaneous increment.
  always_comb begin
    cnt_inc       = (state_q != ST_ASSERT) && (state_d == ST_ASSERT);
    cnt_clr       = chipselect && !write_n && (address == 2'd1);
    reset_count_d = reset_count_q;
    if (cnt_clr) begin
      reset_count_d = '0;
    end else if (cnt_inc && (reset_count_q != {CNT_RST_W{1'b1}})) begin
      reset_count_d = reset_count_q + CNT_RST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ASSERT;
      timer_q       <= '0;
      reset_count_q <= '0;
      lcd_reset_n_q <= 1'b0;
      lcd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      reset_count_q <= reset_count_d;
      lcd_reset_n_q <= lcd_reset_n_d;
      lcd_ready_q   <= lcd_ready_d;
    end
  end

  // Zero-wait-state status read mux.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {26'd0, state_q, 1'b0, ctrl_reset_n, lcd_ready_q, lcd_reset_n_q};
      2'd1:    readdata = {16'd0, reset_count_q};
      2'd2:    readdata = 32'(timer_q);
      default: readdata = '0;
    endcase
  end

  assign lcd_reset_n = lcd_reset_n_q;
  assign lcd_ready   = lcd_ready_q;

endmodule

// File: tb/tb_lt24_reset_sequencer.sv
// Directed bench for lt24_reset_sequencer; expectations are queued by the
// stimulus and compared by an independent monitor process.
module tb_lt24_reset_sequencer;

  localparam int unsigned LOW = 4;
  localparam int unsigned REL = 10;
  localparam int unsigned CW  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctrl_reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        lcd_reset_n;
  logic        lcd_ready;

  lt24_reset_sequencer #(
    .LOW_CYCLES     (LOW),
    .RELEASE_CYCLES (REL),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ctrl_reset_n (ctrl_reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .lcd_reset_n  (lcd_reset_n),
    .lcd_ready    (lcd_ready)
  );

  always #5 clk = ~clk;

  // kind 0: readdata; kind 1: {lcd_ready, lcd_reset_n}
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  exp_t        mon_e;
  logic [31:0] mon_obs;

  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        mon_e   = q.pop_front();
        mon_obs = (mon_e.kind == 0) ? readdata : {30'd0, lcd_ready, lcd_reset_n};
        checks++;
        if (mon_obs !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", mon_e.name, mon_obs, mon_e.exp, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    #1;
    ->chk_ev;
    #1;
  endtask

  task automatic chk_out(input logic [1:0] exp, input string name);
    q.push_back('{kind: 1, exp: 32'(exp), name: name});
    flush();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    q.push_back('{kind: 0, exp: exp, name: name});
    flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n      = 1'b0;
    ctrl_reset_n = 1'b0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    address      = 2'd0;
    writedata    = 32'd0;

    // Power-on
    tick(); tick();
    chk_out(2'b00, "por_in_reset");
    rd(2'd1, 32'd0, "por_count");
    rd(2'd2, 32'd0, "por_timer");
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out(2'b00, "por_hold");
    end
    rd(2'd0, 32'h0, "por_addr0");
    rd(2'd2, 32'd3, "por_timer_sat");

    // Normal release
    ctrl_reset_n = 1'b1;
    chk_out(2'b00, "rel_before_edge");
    tick();
    chk_out(2'b01, "rel_edge");
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out(2'b01, "rel_wait");
    end
    tick();
    chk_out(2'b11, "rel_ready");
    rd(2'd0, 32'h27, "rel_addr0");
    rd(2'd3, 32'h0, "addr3_zero");

    // Short pulse from READY
    tick();
    ctrl_reset_n = 1'b0;
    tick();
    ctrl_reset_n = 1'b1;
    chk_out(2'b00, "sp_low_first");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out(2'b00, "sp_low");
    end
    tick();
    chk_out(2'b01, "sp_release");
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out(2'b01, "sp_wait");
    end
    tick();
    chk_out(2'b11, "sp_ready");
    rd(2'd1, 32'd1, "sp_count");

    // Abort in WAIT at timer 6
    ctrl_reset_n = 1'b0;
    tick();
    ctrl_reset_n = 1'b1;
    chk_out(2'b00, "ab_enter_low");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out(2'b00, "ab_low");
    end
    tick();
    chk_out(2'b01, "ab_wait_entry");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out(2'b01, "ab_wait");
    end
    rd(2'd2, 32'd6, "ab_timer6");
    ctrl_reset_n = 1'b0;
    tick();
    chk_out(2'b00, "ab_assert");
    rd(2'd2, 32'd0, "ab_timer0");
    rd(2'd1, 32'd3, "ab_count");
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out(2'b00, "ab_relow");
    end
    tick();
    chk_out(2'b01, "ab_rerelease");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out(2'b01, "ab_rewait");
    end

    // Asynchronous reset mid-WAIT
    reset_n = 1'b0;
    chk_out(2'b00, "ar_out");
    rd(2'd1, 32'd0, "ar_count");
    rd(2'd2, 32'd0, "ar_timer");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out(2'b00, "ar_low");
    end
    tick();
    chk_out(2'b01, "ar_release");

    // Counter clear colliding with an ASSERT entry
    ctrl_reset_n = 1'b0;
    tick();
    rd(2'd1, 32'd1, "cc_count1");
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_out(2'b01, "cc_wait");
    ctrl_reset_n = 1'b0;
    chipselect   = 1'b1;
    write_n      = 1'b0;
    address      = 2'd1;
    writedata    = 32'hFFFF_FFFF;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk_out(2'b00, "cc_entry");
    rd(2'd1, 32'd0, "cc_clear_wins");

    // Write to address 0 is ignored
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_out(2'b01, "cc_wait2");
    ctrl_reset_n = 1'b0;
    tick();
    rd(2'd1, 32'd1, "cc_count_again");
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd(2'd1, 32'd1, "cc_addr0_ignored");
    rd(2'd0, 32'h0, "cc_addr0_status");
    rd(2'd2, 32'd1, "cc_timer");

    tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
